// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle execute-stage ALU with optional iterative multiply/divide
//
// Purpose: ten single-cycle ops plus RV32M-style MUL/MULH/DIV/DIVU/REM/REMU,
// with valid/ready handshakes on both sides so the execute stage can stall.
// Optional feature macro: ALU_MC_MULDIV_EN (undefined: ops 10-15 return all
// ones in one cycle and busy is tied low).
//
// Ports:
//   clock      in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous abort of any in-flight operation
//   in_valid   in   op_a/op_b/alu_sel valid
//   in_ready   out  operation accepted this cycle (IDLE)
//   op_a       in   operand A [WIDTH]
//   op_b       in   operand B [WIDTH], shift amount in [SHW-1:0]
//   alu_sel    in   operation select [4]
//   out_valid  out  result valid (DONE)
//   out_ready  in   downstream takes the result
//   result     out  registered result [WIDTH]
//   busy       out  iterative operation in progress (BUSY)

module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       alu_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef ALU_MC_MULDIV_EN
   localparam logic [1:0] ST_BUSY = 2'd1;
`endif
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             accept;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] simple_res;

   // flush blocks an accept in the same cycle
   assign accept = in_valid && (state_q == ST_IDLE) && !flush;
   assign shamt  = op_b[SHW-1:0];

   always_comb begin
      simple_res = ALL_ONES;
      case (alu_sel)
         4'd0:    simple_res = op_a + op_b;
         4'd1:    simple_res = op_a - op_b;
         4'd2:    simple_res = op_a >> shamt;
         4'd3:    simple_res = op_a << shamt;
         4'd4:    simple_res = op_a ^ op_b;
         4'd5:    simple_res = op_a | op_b;
         4'd6:    simple_res = op_a & op_b;
         4'd7:    simple_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'd8:    simple_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         4'd9:    simple_res = $signed(op_a) >>> shamt;
         default: simple_res = ALL_ONES;
      endcase
   end

`ifdef ALU_MC_MULDIV_EN
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opd_q, opd_d;
   logic [3:0]         op_q, op_d;
   logic               neg_q, neg_d;

   logic               is_md, is_signed, is_div, is_rem;
   logic               sa, sb, div_zero, ovf, special;
   logic [WIDTH-1:0]   mag_a, mag_b, special_res;

   always_comb begin
      is_md       = (alu_sel >= 4'd10);
      is_signed   = (alu_sel == 4'd11) || (alu_sel == 4'd12) || (alu_sel == 4'd14);
      is_div      = (alu_sel[3:2] == 2'b11);
      is_rem      = (alu_sel == 4'd14) || (alu_sel == 4'd15);
      sa          = is_signed && op_a[WIDTH-1];
      sb          = is_signed && op_b[WIDTH-1];
      mag_a       = sa ? -op_a : op_a;
      mag_b       = sb ? -op_b : op_b;
      div_zero    = is_div && (op_b == '0);
      ovf         = ((alu_sel == 4'd12) || (alu_sel == 4'd14)) &&
                    (op_a == MOST_NEG) && (op_b == ALL_ONES);
      special     = div_zero || ovf;
      special_res = ALL_ONES;
      if (div_zero)
         special_res = is_rem ? op_a : ALL_ONES;
      else if (ovf)
         special_res = is_rem ? '0 : MOST_NEG;
   end

   // One iteration step. Multiply: acc = {partial product, remaining
   // multiplier bits}, shifted right. Divide: acc = {remainder, dividend /
   // quotient bits}, shifted left with a trial subtraction.
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     r_sh;
   logic [WIDTH-1:0]   r_sub;
   logic [2*WIDTH-1:0] mul_n, div_n, step_n, prod_fix;
   logic [WIDTH-1:0]   quo, rem, md_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_n    = {mul_sum, acc_q[WIDTH-1:1]};
      r_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      r_sub    = r_sh[WIDTH-1:0] - opd_q;
      div_n    = (r_sh >= {1'b0, opd_q}) ? {r_sub, acc_q[WIDTH-2:0], 1'b1}
                                         : {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      step_n   = (op_q[3:2] == 2'b11) ? div_n : mul_n;
      quo      = step_n[WIDTH-1:0];
      rem      = step_n[2*WIDTH-1:WIDTH];
      prod_fix = neg_q ? -step_n : step_n;
      case (op_q)
         4'd10:        md_res = prod_fix[WIDTH-1:0];
         4'd11:        md_res = prod_fix[2*WIDTH-1:WIDTH];
         4'd12, 4'd13: md_res = neg_q ? -quo : quo;
         default:      md_res = neg_q ? -rem : rem;
      endcase
   end
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
`ifdef ALU_MC_MULDIV_EN
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      op_d     = op_q;
      neg_d    = neg_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
`ifdef ALU_MC_MULDIV_EN
               if (is_md && !special) begin
                  state_d = ST_BUSY;
                  cnt_d   = SHW'(WIDTH-1);
                  op_d    = alu_sel;
                  // quotient negates on sign mismatch, remainder follows dividend
                  neg_d   = (alu_sel == 4'd14) ? sa : (sa ^ sb);
                  if (is_div) begin
                     acc_d = {{WIDTH{1'b0}}, mag_a};
                     opd_d = mag_b;
                  end else begin
                     acc_d = {{WIDTH{1'b0}}, mag_b};
                     opd_d = mag_a;
                  end
               end else begin
                  state_d  = ST_DONE;
                  result_d = is_md ? special_res : simple_res;
               end
`else
               state_d  = ST_DONE;
               result_d = simple_res;
`endif
            end
         end
`ifdef ALU_MC_MULDIV_EN
         ST_BUSY: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_n;
               if (cnt_q == '0) begin
                  state_d  = ST_DONE;
                  result_d = md_res;
               end else begin
                  cnt_d = cnt_q - SHW'(1);
               end
            end
         end
`endif
         ST_DONE: begin
            if (flush || out_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
`ifdef ALU_MC_MULDIV_EN
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
`ifdef ALU_MC_MULDIV_EN
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
`ifdef ALU_MC_MULDIV_EN
   assign busy      = (state_q == ST_BUSY);
`else
   assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc against an arithmetic reference model

module tb_alu_mc;

   localparam int W = 32;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   op_a = '0;
   logic [31:0]   op_b = '0;
   logic [3:0]    alu_sel = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   result;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .alu_sel   (alu_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      case (sel)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a >> b[4:0];
         4'd3: return a << b[4:0];
         4'd4: return a ^ b;
         4'd5: return a | b;
         4'd6: return a & b;
         4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8: return (a < b) ? 32'd1 : 32'd0;
         4'd9: return $signed(a) >>> b[4:0];
`ifdef ALU_MC_MULDIV_EN
         4'd10: begin
            up = {32'd0, a} * {32'd0, b};
            return up[31:0];
         end
         4'd11: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp[63:32];
         end
         4'd12: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
            return $signed(a) / $signed(b);
         end
         4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd14: begin
            if (b == 0) return a;
            if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
         end
         4'd15: return (b == 0) ? a : a % b;
`endif
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // edges from the accept edge (inclusive) until out_valid is seen
   function automatic int ref_lat(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MC_MULDIV_EN
      if (sel < 4'd10) return 1;
      if (sel >= 4'd12 && b == 0) return 1;
      if ((sel == 4'd12 || sel == 4'd14) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
      return W + 1;
`else
      return 1;
`endif
   endfunction

   // Present one op, scramble inputs after the accept edge, wait (bounded) for out_valid.
   // Leaves the DUT in DONE with out_ready low.
   task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt);
      @(negedge clock);
      in_valid = 1'b1;
      alu_sel  = sel;
      op_a     = a;
      op_b     = b;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      alu_sel  = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      lat  = 1;
      bcnt = 0;
      while (!out_valid && lat < 100) begin
         if (busy) bcnt++;
         @(posedge clock);
         #1;
         lat++;
      end
      res = result;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h exp 0", result); end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_add();
      logic [31:0] r; int lat; int bc;
      do_op(4'd0, 32'h7FFF_FFFF, 32'h1, r, lat, bc);
      n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL add_result: got %h exp 80000000", r); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d exp 1", lat); end
      release_out();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL add_handoff: got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
   endtask

   task automatic test_directed_alu();
      logic [31:0] r; int lat; int bc;
      do_op(4'd9, 32'hF000_0000, 32'h24, r, lat, bc);
      n_cmp++; if (r !== 32'hFF00_0000) begin n_err++; $display("FAIL sra: got %h exp ff000000", r); end
      release_out();
      do_op(4'd7, 32'hFFFF_FFFF, 32'h1, r, lat, bc);
      n_cmp++; if (r !== 32'h1) begin n_err++; $display("FAIL slt: got %h exp 1", r); end
      release_out();
      do_op(4'd8, 32'hFFFF_FFFF, 32'h1, r, lat, bc);
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL sltu: got %h exp 0", r); end
      release_out();
   endtask

   task automatic test_random_alu();
      logic [31:0] r, a, b, e; logic [3:0] s; int lat; int bc;
      for (int i = 0; i < 60; i++) begin
         s = 4'($urandom_range(0, 9));
         a = $urandom;
         b = $urandom;
         e = ref_alu(s, a, b);
         do_op(s, a, b, r, lat, bc);
         n_cmp++; if (r !== e) begin n_err++; $display("FAIL rand_alu sel=%0d a=%h b=%h: got %h exp %h", s, a, b, r, e); end
         n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rand_alu_latency sel=%0d: got %0d exp 1", s, lat); end
         release_out();
      end
   endtask

`ifdef ALU_MC_MULDIV_EN
   task automatic test_muldiv_directed();
      logic [31:0] r; int lat; int bc;
      do_op(4'd11, 32'hFFFF_FFFE, 32'd3, r, lat, bc);
      n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulh: got %h exp ffffffff", r); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mulh_latency: got %0d exp 33", lat); end
      n_cmp++; if (bc !== 32) begin n_err++; $display("FAIL mulh_busy_cycles: got %0d exp 32", bc); end
      release_out();
      do_op(4'd10, 32'hFFFF_FFFE, 32'd3, r, lat, bc);
      n_cmp++; if (r !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mul: got %h exp fffffffa", r); end
      release_out();
      do_op(4'd12, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
      n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg: got %h exp fffffffd", r); end
      release_out();
      do_op(4'd14, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
      n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_neg: got %h exp ffffffff", r); end
      release_out();
      do_op(4'd13, 32'd5, 32'd0, r, lat, bc);
      n_cmp++; if (r !== 32'hFFFF_FFFF || lat !== 1) begin n_err++; $display("FAIL divu_by_zero: got %h lat %0d exp ffffffff lat 1", r, lat); end
      release_out();
      do_op(4'd14, 32'd5, 32'd0, r, lat, bc);
      n_cmp++; if (r !== 32'd5 || lat !== 1) begin n_err++; $display("FAIL rem_by_zero: got %h lat %0d exp 5 lat 1", r, lat); end
      release_out();
      do_op(4'd12, MIN_NEG, 32'hFFFF_FFFF, r, lat, bc);
      n_cmp++; if (r !== MIN_NEG || lat !== 1) begin n_err++; $display("FAIL div_overflow: got %h lat %0d exp 80000000 lat 1", r, lat); end
      release_out();
   endtask

   task automatic test_random_muldiv();
      logic [31:0] r, a, b, e; logic [3:0] s; int lat; int bc; int el;
      for (int i = 0; i < 24; i++) begin
         s = 4'($urandom_range(10, 15));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 20));
            default: ;
         endcase
         e  = ref_alu(s, a, b);
         el = ref_lat(s, a, b);
         do_op(s, a, b, r, lat, bc);
         n_cmp++; if (r !== e) begin n_err++; $display("FAIL rand_md sel=%0d a=%h b=%h: got %h exp %h", s, a, b, r, e); end
         n_cmp++; if (lat !== el) begin n_err++; $display("FAIL rand_md_latency sel=%0d: got %0d exp %0d", s, lat, el); end
         release_out();
      end
   endtask

   task automatic test_flush_busy();
      logic [31:0] before, r; int lat; int bc; int seen;
      before = result;
      @(negedge clock);
      in_valid = 1'b1; alu_sel = 4'd11; op_a = $urandom; op_b = $urandom;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b exp 1", busy); end
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL flush_to_idle: got ir=%b busy=%b exp ir=1 busy=0", in_ready, busy); end
      seen = 0;
      repeat (40) begin
         if (out_valid) seen++;
         @(posedge clock);
         #1;
      end
      n_cmp++; if (seen !== 0 || result !== before) begin n_err++; $display("FAIL flush_no_result: got %0d valid cycles result %h exp 0 cycles result %h", seen, result, before); end
      do_op(4'd0, 32'd100, 32'd23, r, lat, bc);
      n_cmp++; if (r !== 32'd123 || lat !== 1) begin n_err++; $display("FAIL flush_then_add: got %h lat %0d exp 7b lat 1", r, lat); end
      release_out();
   endtask
`else
   task automatic test_macro_off();
      logic [31:0] r; int lat; int bc;
      do_op(4'd12, 32'd10, 32'd2, r, lat, bc);
      n_cmp++; if (r !== 32'hFFFF_FFFF || lat !== 1 || bc !== 0) begin n_err++; $display("FAIL macro_off_div: got %h lat %0d busy %0d exp ffffffff lat 1 busy 0", r, lat, bc); end
      release_out();
      for (int s = 10; s < 16; s++) begin
         do_op(4'(s), $urandom, $urandom, r, lat, bc);
         n_cmp++; if (r !== 32'hFFFF_FFFF || lat !== 1 || bc !== 0) begin n_err++; $display("FAIL macro_off_sel%0d: got %h lat %0d busy %0d exp ffffffff lat 1 busy 0", s, r, lat, bc); end
         release_out();
      end
   endtask
`endif

   task automatic test_backpressure();
      logic [31:0] r, e, a, b; int lat; int bc; int bad;
      a = $urandom; b = $urandom;
      e = ref_alu(4'd4, a, b);
      do_op(4'd4, a, b, r, lat, bc);
      bad = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         op_a = $urandom; op_b = $urandom; alu_sel = 4'($urandom);
         @(posedge clock);
         #1;
         if (result !== e || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL backpressure_hold: got %0d bad cycles exp 0 (result %h exp %h)", bad, result, e); end
      // in_valid still high across the DONE->IDLE edge: no accept may happen there
      op_a = 32'd1; op_b = 32'd2; alu_sel = 4'd0;
      release_out();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL handoff_no_accept: got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || result !== 32'd3) begin n_err++; $display("FAIL accept_after_handoff: got ov=%b result %h exp ov=1 result 3", out_valid, result); end
      release_out();
   endtask

   task automatic test_flush_done_idle();
      logic [31:0] r; int lat; int bc;
      do_op(4'd1, 32'd50, 32'd8, r, lat, bc);
      flush = 1'b1;
      @(posedge clock);
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd42) begin n_err++; $display("FAIL flush_done: got ov=%b ir=%b result %h exp ov=0 ir=1 result 2a", out_valid, in_ready, result); end
      // flush in IDLE blocks a simultaneous accept
      in_valid = 1'b1; alu_sel = 4'd0; op_a = 32'd7; op_b = 32'd7;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle_blocks: got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] r; int lat; int bc;
      do_op(4'd5, 32'h1234_0000, 32'h0000_5678, r, lat, bc);
      #3;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 32'h0) begin n_err++; $display("FAIL reset_midop: got ov=%b ir=%b busy=%b result %h exp 0 1 0 0", out_valid, in_ready, busy, result); end
`ifdef ALU_MC_MULDIV_EN
      @(negedge clock);
      reset_n = 1'b1;
      in_valid = 1'b1; alu_sel = 4'd10; op_a = $urandom; op_b = $urandom;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clock); #1; end
      #3;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin n_err++; $display("FAIL reset_busy_drop: got ov=%b busy=%b result %h exp 0 0 0", out_valid, busy, result); end
`endif
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_directed_alu();
      test_random_alu();
`ifdef ALU_MC_MULDIV_EN
      test_muldiv_directed();
      test_random_muldiv();
      test_flush_busy();
`else
      test_macro_off();
`endif
      test_backpressure();
      test_flush_done_idle();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised execute-stage ALU for the RISC-V core, succeeding the single-cycle ALU. It keeps the existing ten-op encoding and adds iterative multiply and divide (RV32M subset). It moves operands and results through valid/ready handshakes, so the pipeline can stall the execute stage while a long operation runs. It sits between the operand-select muxes and the execute/memory pipeline register.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 8 and a power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount bits taken from the low end of `op_b`.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous abort of any in-flight operation.
- `in_valid` input 1: operands and `alu_sel` are valid.
- `in_ready` output 1: the block accepts an operation this cycle.
- `op_a` input WIDTH: operand A (rs1 / PC path).
- `op_b` input WIDTH: operand B (rs2 / immediate path).
- `alu_sel` input 4: operation select.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: downstream takes the result.
- `result` output WIDTH: registered result.
- `busy` output 1: high in the BUSY state.

## Operation
- Encoding:
  - 0 ADD, 1 SUB, 2 SRL, 3 SLL, 4 XOR, 5 OR, 6 AND, 7 SLT (signed), 8 SLTU, 9 SRA. Shifts use `op_b[SHW-1:0]`.
  - 10 MUL (low WIDTH bits), 11 MULH (signed×signed, high WIDTH bits).
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- States:
  - IDLE: `in_ready`=1.
  - BUSY: iterating; `in_ready`=0.
  - DONE: `out_valid`=1, `in_ready`=0.
- Accept happens when `in_valid && in_ready`. Operands and `alu_sel` are captured at the accept edge; later input changes have no effect.
- Ops 0–9, and ops 10–15 that resolve without iteration: go IDLE→DONE, with the result computed and registered at the accept edge.
- Ops 10–15 otherwise: go IDLE→BUSY.
  - The iteration counter loads WIDTH-1 and decrements each BUSY cycle.
  - At count 0 the state moves BUSY→DONE and the final result is registered.
- MUL/MULH: radix-2 shift-add on operand magnitudes into a 2·WIDTH accumulator. For MULH, the product is negated when the operand signs differ.
- DIV/DIVU/REM/REMU: restoring division on magnitudes. The quotient is negated when the signs differ. The remainder takes the dividend's sign.
- Special cases resolve without iteration and go straight to DONE:
  - Divide by zero: quotient = all ones; remainder = `op_a`.
  - Signed overflow (DIV/REM of the most negative value by -1): quotient = the most negative value (`{1'b1,{WIDTH-1{1'b0}}}`); remainder = 0.
- DONE→IDLE on `out_ready`. `result` holds its value until the next completion.
- `flush`:
  - In BUSY or DONE: the state goes to IDLE on the next edge and `out_valid` drops. No result is produced.
  - Takes priority over `in_valid` accept and over `out_ready`.
  - Has no effect in IDLE other than blocking an accept in the same cycle.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, counter=0.
- `reset_n` low mid-operation: the operation is dropped immediately; no partial result is ever presented.
- Latency, measured as accept edge to `out_valid` high:
  - Ops 0–9 and special cases: 1 cycle.
  - Iterative ops: WIDTH+1 cycles (33 for WIDTH=32).
- Throughput: one op per 2 cycles minimum. No accept occurs in the same cycle as a DONE→IDLE handoff.
- `out_valid` stays asserted with a stable `result` until a cycle where `out_ready`=1.
- `in_ready`, `out_valid` and `busy` are decoded purely from registered state; they have no combinational path from any input.

## Configuration
- `ALU_MC_MULDIV_EN` defined: ops 10–15 are implemented as above.
- Not defined: the multiply/divide datapath and counter are omitted.
  - Ops 10–15 complete in 1 cycle with `result` = all ones, matching the single-cycle default.
  - `busy` is tied to 0.

## Test plan
- Reset then ADD: `reset_n` low → `in_ready`=1, `out_valid`=0, `result`=0. Accept ADD 0x7FFFFFFF + 1 → next cycle `out_valid`=1, `result`=0x80000000.
- SRA and SLT: SRA 0xF0000000 by `op_b`=0x24 (shamt 4) → 0xFF000000. SLT of -1 vs 1 → 1. SLTU of the same operands → 0.
- MULH: -2 × 3 → `out_valid` exactly 33 cycles after accept. MULH → 0xFFFFFFFF; MUL of the same operands → 0xFFFFFFFA. `busy` is high for 32 cycles.
- Division corners:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Both in 1 cycle.
  - DIV 0x80000000 / -1 → 0x80000000 in 1 cycle.
- Backpressure and flush:
  - Hold `out_ready`=0 for 10 cycles after DONE → `result` is stable and `in_ready`=0 throughout.
  - Assert `flush` at BUSY cycle 5 → IDLE next edge, `out_valid` never rises, and a following ADD completes correctly.
- Macro off, with `ALU_MC_MULDIV_EN` undefined: DIV 10/2 → `result`=0xFFFFFFFF after 1 cycle, `busy` never asserted.
